// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared state encoding and sizing helpers for multi_pad_controller
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } ctrl_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width able to hold 0..max_count without wrapping.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Cycles from the first sample-high cycle to the ready cycle, inclusive.
    function automatic int frame_cycles(input int latch_cycles, input int num_buttons,
                                        input int clk_div);
        return latch_cycles + num_buttons * clk_div + (num_buttons - 1) * clk_div + 1;
    endfunction

endpackage

// File: rtl/pad_phase_timer.sv
// rtl/pad_phase_timer.sv - loadable down-counter; o_done is high while the count is zero
module pad_phase_timer
    import controller_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INIT_VALUE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= WIDTH'(INIT_VALUE);
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/multi_pad_controller.sv
// rtl/multi_pad_controller.sv - shared-latch serial reader for NUM_PADS pads; optional CTRL_CHANGE_DETECT_EN
module multi_pad_controller
    import controller_pkg::*;
#(
    parameter int NUM_PADS      = 2,
    parameter int NUM_BUTTONS   = 16,
    parameter int CLK_DIV       = 30,
    parameter int LATCH_CYCLES  = 120,
    parameter int POLL_INTERVAL = 166667
) (
    input  logic                            SYSCLK,
    input  logic                            NSYSRESET,
    input  logic                            start,
    input  logic                            auto_en,
    input  logic [NUM_PADS-1:0]             data,
    output logic                            sample,
    output logic                            poll,
    output logic                            busy,
    output logic                            ready,
    output logic [NUM_PADS*NUM_BUTTONS-1:0] buttonData,
    output logic [NUM_PADS-1:0]             changed
);

    localparam int PW = cnt_width(max2(LATCH_CYCLES, CLK_DIV));
    localparam int IW = cnt_width(POLL_INTERVAL);
    localparam int KW = cnt_width(NUM_BUTTONS);
    localparam int BW = NUM_PADS * NUM_BUTTONS;

    ctrl_state_t     r_state;
    logic [KW-1:0]   r_k;
    logic [BW-1:0]   r_shift;
    logic [BW-1:0]   r_btn;
    logic            r_sample;
    logic            r_poll;
    logic            r_busy;
    logic            r_ready;
    logic            r_pending;

    logic            w_phase_done;
    logic            w_phase_load;
    logic [PW-1:0]   w_phase_val;
    logic            w_tick;
    logic            w_trig;
    logic            w_last_bit;
    logic [BW-1:0]   w_shift_next;

    pad_phase_timer #(
        .WIDTH      (PW),
        .INIT_VALUE (0)
    ) u_phase_timer (
        .i_clk   (SYSCLK),
        .i_rst_n (NSYSRESET),
        .i_load  (w_phase_load),
        .i_value (w_phase_val),
        .o_done  (w_phase_done)
    );

    // Starting at the terminal count makes the first tick land POLL_INTERVAL-1 cycles after reset.
    pad_phase_timer #(
        .WIDTH      (IW),
        .INIT_VALUE (POLL_INTERVAL - 1)
    ) u_interval_timer (
        .i_clk   (SYSCLK),
        .i_rst_n (NSYSRESET),
        .i_load  (w_tick),
        .i_value (IW'(POLL_INTERVAL - 1)),
        .o_done  (w_tick)
    );

    assign w_trig     = start | (auto_en & w_tick);
    assign w_last_bit = (r_k == KW'(NUM_BUTTONS - 1));

    always_comb begin
        w_phase_load = 1'b0;
        w_phase_val  = PW'(CLK_DIV - 1);
        case (r_state)
            IDLE: begin
                w_phase_load = w_trig | r_pending;
                w_phase_val  = PW'(LATCH_CYCLES - 1);
            end
            LATCH, LOW, HIGH: w_phase_load = w_phase_done;
            default: ;
        endcase
    end

    // Shift image with the current bit of every pad merged in, so DONE never sees a stale bit.
    always_comb begin
        w_shift_next = r_shift;
        for (int p = 0; p < NUM_PADS; p++) begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if (KW'(b) == r_k) begin
                    w_shift_next[p*NUM_BUTTONS + b] = ~data[p];
                end
            end
        end
    end

`ifdef CTRL_CHANGE_DETECT_EN
    logic [NUM_PADS-1:0] r_changed;
    logic [NUM_PADS-1:0] w_diff;

    always_comb begin
        w_diff = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            w_diff[p] = (w_shift_next[p*NUM_BUTTONS +: NUM_BUTTONS] !=
                         r_btn[p*NUM_BUTTONS +: NUM_BUTTONS]);
        end
    end
`endif

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_shift   <= '0;
            r_btn     <= '0;
            r_sample  <= 1'b0;
            r_poll    <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_pending <= 1'b0;
`ifdef CTRL_CHANGE_DETECT_EN
            r_changed <= '0;
`endif
        end else begin
            if (r_state != IDLE && w_trig) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_trig || r_pending) begin
                        r_state   <= LATCH;
                        r_sample  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                LATCH: begin
                    if (w_phase_done) begin
                        r_state  <= LOW;
                        r_sample <= 1'b0;
                        r_k      <= '0;
                    end
                end
                LOW: begin
                    if (w_phase_done) begin
                        r_shift <= w_shift_next;
                        if (w_last_bit) begin
                            r_state <= DONE;
                            r_btn   <= w_shift_next;
                            r_ready <= 1'b1;
`ifdef CTRL_CHANGE_DETECT_EN
                            r_changed <= w_diff;
`endif
                        end else begin
                            r_state <= HIGH;
                            r_poll  <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (w_phase_done) begin
                        r_state <= LOW;
                        r_poll  <= 1'b0;
                        r_k     <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
`ifdef CTRL_CHANGE_DETECT_EN
                    r_changed <= '0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sample     = r_sample;
    assign poll       = r_poll;
    assign busy       = r_busy;
    assign ready      = r_ready;
    assign buttonData = r_btn;
`ifdef CTRL_CHANGE_DETECT_EN
    assign changed    = r_changed;
`else
    assign changed    = '0;
`endif

endmodule

// File: tb/tb_multi_pad_controller.sv
// tb/tb_multi_pad_controller.sv - self-checking bench for multi_pad_controller
module tb_multi_pad_controller;

    localparam int FRAME_LEN = 67;

    logic        SYSCLK = 1'b0;
    logic        NSYSRESET = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic [1:0]  data = 2'b11;
    logic        sample, poll, busy, ready;
    logic [15:0] buttonData;
    logic [1:0]  changed;

    multi_pad_controller #(
        .NUM_PADS      (2),
        .NUM_BUTTONS   (8),
        .CLK_DIV       (4),
        .LATCH_CYCLES  (6),
        .POLL_INTERVAL (200)
    ) dut (
        .SYSCLK     (SYSCLK),
        .NSYSRESET  (NSYSRESET),
        .start      (start),
        .auto_en    (auto_en),
        .data       (data),
        .sample     (sample),
        .poll       (poll),
        .busy       (busy),
        .ready      (ready),
        .buttonData (buttonData),
        .changed    (changed)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad model: mode 0 = shift word, 1 = missing (line high), 2 = stuck low.
    logic [1:0] pmode [2];
    logic [7:0] pword [2];
    int         pidx = 0;
    logic       pm_prev_poll = 1'b0;

    initial begin
        pmode[0] = 2'd1; pmode[1] = 2'd1;
        pword[0] = 8'h00; pword[1] = 8'h00;
    end

    always @(negedge SYSCLK) begin
        if (sample) pidx = 0;
        else if (poll && !pm_prev_poll) pidx++;
        pm_prev_poll = poll;
        for (int p = 0; p < 2; p++) begin
            case (pmode[p])
                2'd0:    data[p] = (pidx < 8) ? ~pword[p][pidx] : 1'b1;
                2'd2:    data[p] = 1'b0;
                default: data[p] = 1'b1;
            endcase
        end
    end

    // Scoreboard and frame-shape monitor.
    logic [15:0] sb [$];
    logic [15:0] prev_word = 16'h0;
    logic [15:0] auto_exp = 16'h0;
    logic [15:0] exp_w;
    logic [1:0]  chexp;
    bit          auto_mode = 0;
    int          last_rise = -1;
    int          ready_cnt = 0;
    int          cyc = 0;
    int          fcnt = 0, scnt = 0, pcnt = 0, phcnt = 0;
    logic        m_prev_sample = 1'b0, m_prev_poll = 1'b0, m_prev_ready = 1'b0;

    always @(negedge SYSCLK) begin
        cyc++;
        if (!NSYSRESET) begin
            prev_word = 16'h0;
            fcnt = 0; scnt = 0; pcnt = 0; phcnt = 0;
            m_prev_sample = 1'b0; m_prev_poll = 1'b0; m_prev_ready = 1'b0;
        end else begin
            if (sample && !m_prev_sample) begin
                if (auto_mode && last_rise >= 0) check("auto_spacing", 64'(cyc - last_rise), 64'd200);
                last_rise = cyc;
                fcnt = 1; scnt = 0; pcnt = 0; phcnt = 0;
            end else if (fcnt > 0) begin
                fcnt++;
            end
            if (sample) scnt++;
            if (poll && !m_prev_poll) pcnt++;
            if (poll) phcnt++;
            if (m_prev_ready) check("busy_after_ready", 64'(busy), 64'd0);
            if (ready) begin
                ready_cnt++;
                check("frame_len", 64'(fcnt), 64'(FRAME_LEN));
                check("sample_cycles", 64'(scnt), 64'd6);
                check("poll_pulses", 64'(pcnt), 64'd7);
                check("poll_high_cycles", 64'(phcnt), 64'd28);
                check("busy_in_ready", 64'(busy), 64'd1);
                if (auto_mode) begin
                    exp_w = auto_exp;
                end else if (sb.size() == 0) begin
                    check("unexpected_ready", 64'd1, 64'd0);
                    exp_w = buttonData;
                end else begin
                    exp_w = sb.pop_front();
                end
                check("buttonData", 64'(buttonData), 64'(exp_w));
`ifdef CTRL_CHANGE_DETECT_EN
                chexp[0] = (exp_w[7:0] != prev_word[7:0]);
                chexp[1] = (exp_w[15:8] != prev_word[15:8]);
`else
                chexp = 2'b00;
`endif
                check("changed", 64'(changed), 64'(chexp));
                prev_word = exp_w;
                fcnt = 0;
            end else begin
                check("changed_idle", 64'(changed), 64'd0);
            end
            m_prev_sample = sample; m_prev_poll = poll; m_prev_ready = ready;
        end
    end

    typedef struct {
        logic [1:0]  mode0;
        logic [1:0]  mode1;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic pulse_start();
        @(posedge SYSCLK); #1 start = 1'b1;
        @(posedge SYSCLK); #1 start = 1'b0;
    endtask

    task automatic wait_ready(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge SYSCLK); #1;
            if (ready_cnt >= target) break;
        end
        check(name, 64'(ready_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge SYSCLK); #1;
            if (!busy) break;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    int base;

    initial begin
        vecs[0] = '{2'd0, 2'd0, 8'hA5, 8'h00, 16'h00A5};
        vecs[1] = '{2'd0, 2'd0, 8'hA5, 8'h00, 16'h00A5};
        vecs[2] = '{2'd0, 2'd0, 8'hA5, 8'h01, 16'h01A5};
        vecs[3] = '{2'd1, 2'd1, 8'h00, 8'h00, 16'h0000};
        vecs[4] = '{2'd2, 2'd2, 8'h00, 8'h00, 16'hFFFF};
        vecs[5] = '{2'd0, 2'd0, 8'h3C, 8'hC3, 16'hC33C};
        vecs[6] = '{2'd0, 2'd1, 8'h80, 8'h5A, 16'h0080};

        repeat (3) @(negedge SYSCLK);
        #1 check("reset_outputs", 64'({sample, poll, busy, ready, buttonData, changed}), 64'd0);
        @(posedge SYSCLK); #1 NSYSRESET = 1'b1;
        repeat (5) @(negedge SYSCLK);
        #1 check("idle_after_reset", 64'({sample, busy}), 64'd0);

        // Table-driven single frames, including stuck lines and change detection.
        for (int i = 0; i < 7; i++) begin
            pmode[0] = vecs[i].mode0; pmode[1] = vecs[i].mode1;
            pword[0] = vecs[i].w0;    pword[1] = vecs[i].w1;
            sb.push_back(vecs[i].exp);
            base = ready_cnt;
            pulse_start();
            wait_ready(base + 1, 200, "vec_ready_timeout");
        end

        // Two requests during a frame collapse into exactly one extra frame.
        pmode[0] = 2'd0; pmode[1] = 2'd0; pword[0] = 8'h5A; pword[1] = 8'h00;
        sb.push_back(16'h005A); sb.push_back(16'h005A);
        base = ready_cnt;
        pulse_start();
        repeat (9) @(posedge SYSCLK);
        pulse_start();
        repeat (29) @(posedge SYSCLK);
        pulse_start();
        wait_ready(base + 1, 200, "pending_first_timeout");
        @(negedge SYSCLK); #1 check("idle_gap_sample", 64'({sample, busy}), 64'd0);
        @(negedge SYSCLK); #1 check("pending_restart", 64'(sample), 64'd1);
        wait_ready(base + 2, 200, "pending_second_timeout");
        repeat (150) @(negedge SYSCLK);
        #1 check("no_third_frame", 64'(ready_cnt - base), 64'd2);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        // Periodic frames from the interval timer.
        auto_exp = 16'h005A; last_rise = -1; auto_mode = 1;
        base = ready_cnt;
        @(posedge SYSCLK); #1 auto_en = 1'b1;
        repeat (1000) @(posedge SYSCLK);
        #1 auto_en = 1'b0;
        check("auto_ready_count", 64'((ready_cnt - base >= 4) && (ready_cnt - base <= 6)), 64'd1);
        wait_idle(200);
        repeat (5) @(negedge SYSCLK);
        auto_mode = 0;

        // Reset mid-frame aborts at once with no ready pulse.
        pword[0] = 8'hA5; pword[1] = 8'h00;
        sb.push_back(16'h00A5);
        pulse_start();
        for (int i = 0; i < 20 && !sample; i++) @(negedge SYSCLK);
        check("abort_frame_started", 64'(sample), 64'd1);
        repeat (29) @(posedge SYSCLK);
        #2 NSYSRESET = 1'b0;
        #1 check("abort_outputs", 64'({sample, poll, busy, ready, buttonData}), 64'd0);
        sb.delete();
        base = ready_cnt;
        repeat (3) @(posedge SYSCLK);
        #1 NSYSRESET = 1'b1;
        repeat (100) @(negedge SYSCLK);
        #1 check("no_ready_after_abort", 64'(ready_cnt - base), 64'd0);
        check("idle_until_start", 64'({sample, busy, buttonData}), 64'd0);

        // Normal operation resumes; change flags compare against the cleared word.
        sb.push_back(16'h00A5);
        pulse_start();
        wait_ready(base + 1, 200, "post_reset_timeout");
        repeat (5) @(negedge SYSCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
